// File: rtl/two_col_mac_seq.sv
// Beat sequencer and dual accumulator for the two-column packed-INT8 MAC.
// Feeds one operand triple per cycle, tracks the one-cycle MAC latency and holds both dot products for the consumer.
module two_col_mac_seq #(
    parameter int LEN_W  = 12,
    parameter int ACC_DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_dat,
    input  logic [7:0]        in_wt0,
    input  logic [7:0]        in_wt1,
    output logic [7:0]        mac_dat,
    output logic [7:0]        mac_wt0,
    output logic [7:0]        mac_wt1,
    input  logic [15:0]       mac_sum0,
    input  logic [15:0]       mac_sum1,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_DW-1:0] out_sum0,
    output logic [ACC_DW-1:0] out_sum1,
    output logic [1:0]        dbg_state
);

    // Handshakes: a beat moves when in_valid & in_ready at a rising edge; results
    // move when out_valid & out_ready. Ready never depends on valid on either side.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [LEN_W-1:0]          rem;
    logic                      v1;
    logic                      v2;
    logic signed [ACC_DW-1:0]  acc0;
    logic signed [ACC_DW-1:0]  acc1;
    logic signed [ACC_DW-1:0]  prod0;
    logic signed [ACC_DW-1:0]  prod1;
    logic                      accept;

    assign accept = in_valid & in_ready;
    assign prod0  = ACC_DW'($signed(mac_sum0));
    assign prod1  = ACC_DW'($signed(mac_sum1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (cfg_len == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = (rem != '0);
                if (in_valid && (rem != '0) && (rem == LEN_W'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Once v1 is clear, the last product (tagged by v2) lands in the
                // accumulators on this same edge, so DONE shows the final sums.
                if (!v1) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            acc0    <= '0;
            acc1    <= '0;
            mac_dat <= '0;
            mac_wt0 <= '0;
            mac_wt1 <= '0;
        end else begin
            state   <= state_nxt;
            v1      <= accept;
            v2      <= v1;
            mac_dat <= accept ? in_dat : '0;
            mac_wt0 <= accept ? in_wt0 : '0;
            mac_wt1 <= accept ? in_wt1 : '0;
            if (state == IDLE && start) begin
                rem  <= cfg_len;
                acc0 <= '0;
                acc1 <= '0;
            end else begin
                if (accept) rem <= rem - LEN_W'(1);
                if (v2) begin
                    acc0 <= acc0 + prod0;
                    acc1 <= acc1 + prod1;
                end
            end
        end
    end

    assign out_sum0  = acc0;
    assign out_sum1  = acc1;
    assign dbg_state = state;

endmodule

// File: tb/tb_two_col_mac_seq.sv
// Bench for two_col_mac_seq: directed vector table, reset-abort sequence and
// randomized jobs scored against a plain dot-product model.
module tb_two_col_mac_seq;

    localparam int LEN_W  = 12;
    localparam int ACC_DW = 32;
    localparam int NJOBS  = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_dat;
    logic [7:0]        in_wt0;
    logic [7:0]        in_wt1;
    logic [7:0]        mac_dat;
    logic [7:0]        mac_wt0;
    logic [7:0]        mac_wt1;
    logic [15:0]       mac_sum0 = '0;
    logic [15:0]       mac_sum1 = '0;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_DW-1:0] out_sum0;
    logic [ACC_DW-1:0] out_sum1;
    logic [1:0]        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [2*ACC_DW-1:0] exp_q[$];

    typedef struct {
        int len;
        int dat;
        int wt0;
        int wt1;
        int bubbles;
        int hold;
        int poke_start;
        int exp0;
        int exp1;
        int exp_cyc;
    } vec_t;

    vec_t vecs[4];
    vec_t post_rst;

    two_col_mac_seq #(.LEN_W(LEN_W), .ACC_DW(ACC_DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (in_dat),
        .in_wt0    (in_wt0),
        .in_wt1    (in_wt1),
        .mac_dat   (mac_dat),
        .mac_wt0   (mac_wt0),
        .mac_wt1   (mac_wt1),
        .mac_sum0  (mac_sum0),
        .mac_sum1  (mac_sum1),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum0  (out_sum0),
        .out_sum1  (out_sum1),
        .dbg_state (dbg_state)
    );

    // clock / edge counter / MAC model (one-cycle registered signed products)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        mac_sum0 <= 16'($signed(mac_dat) * $signed(mac_wt0));
        mac_sum1 <= 16'($signed(mac_dat) * $signed(mac_wt1));
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum0"},  out_sum0,       32'd0);
        check({tag, "_out_sum1"},  out_sum1,       32'd0);
        check({tag, "_mac"}, 32'({mac_dat, mac_wt0, mac_wt1}), 32'd0);
    endtask

    // Directed job: every beat carries the same operands.
    task automatic run_job(input vec_t v);
        int t_edge;
        int waitc;
        logic [7:0] ed;
        logic [7:0] e0;
        logic [7:0] e1;
        ed = v.dat[7:0];
        e0 = v.wt0[7:0];
        e1 = v.wt1[7:0];
        start   = 1'b1;
        cfg_len = LEN_W'(v.len);
        @(negedge clk);
        start  = 1'b0;
        t_edge = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
        if (v.len == 0) check("zero_len_in_ready", 32'(in_ready), 32'd0);
        for (int b = 0; b < v.len; b++) begin
            if (v.bubbles != 0 && b > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
                check("mac_zero_in_bubble", 32'({mac_dat, mac_wt0, mac_wt1}), 32'd0);
            end
            in_valid = 1'b1;
            in_dat   = ed;
            in_wt0   = e0;
            in_wt1   = e1;
            waitc    = 0;
            while (!in_ready && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            t_edge   = cyc;
            in_valid = 1'b0;
            check("mac_operands", 32'({mac_dat, mac_wt0, mac_wt1}), 32'({ed, e0, e1}));
        end
        if (v.len > 0) check("in_ready_after_last", 32'(in_ready), 32'd0);
        waitc = 0;
        while (!out_valid && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("out_valid_cycle", 32'(cyc - t_edge + 1), 32'(v.exp_cyc));
        check("out_sum0", out_sum0, 32'(v.exp0));
        check("out_sum1", out_sum1, 32'(v.exp1));
        for (int k = 0; k < v.hold; k++) begin
            if (v.poke_start != 0 && k == 1) begin
                start   = 1'b1;
                cfg_len = LEN_W'(5);
            end
            @(negedge clk);
            start = 1'b0;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_busy",      32'(busy),      32'd1);
            check("hold_sum0",      out_sum0,       32'(v.exp0));
            check("hold_sum1",      out_sum1,       32'(v.exp1));
        end
        // start coinciding with the DONE->IDLE edge must be ignored
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_len   = LEN_W'(3);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("post_done_out_valid", 32'(out_valid), 32'd0);
        check("post_done_busy",      32'(busy),      32'd0);
        check("post_done_sum0",      out_sum0,       32'(v.exp0));
    endtask

    task automatic random_job();
        int len;
        int idx;
        int guard;
        bit acc;
        bit hs;
        bit done;
        logic [7:0] bd[$];
        logic [7:0] b0[$];
        logic [7:0] b1[$];
        logic [7:0] d;
        logic [7:0] w0;
        logic [7:0] w1;
        longint e0;
        longint e1;
        logic [2*ACC_DW-1:0] exp;
        len = $urandom_range(64, 1);
        e0  = 0;
        e1  = 0;
        for (int b = 0; b < len; b++) begin
            d  = 8'($urandom);
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            bd.push_back(d);
            b0.push_back(w0);
            b1.push_back(w1);
            e0 += longint'($signed(d)) * longint'($signed(w0));
            e1 += longint'($signed(d)) * longint'($signed(w1));
        end
        exp_q.push_back({e1[ACC_DW-1:0], e0[ACC_DW-1:0]});
        start   = 1'b1;
        cfg_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < len && guard < 1000) begin
            in_valid = ($urandom_range(7, 0) != 0);
            in_dat   = bd[idx];
            in_wt0   = b0[idx];
            in_wt1   = b1[idx];
            start    = ($urandom_range(15, 0) == 0);
            cfg_len  = LEN_W'($urandom_range(64, 0));
            acc      = in_valid && in_ready;
            @(negedge clk);
            guard++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < len) check("rand_feed_timeout", 32'(idx), 32'(len));
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 1000) begin
            out_ready = ($urandom_range(3, 0) != 0);
            hs        = out_valid && out_ready;
            if (hs) begin
                exp = exp_q.pop_front();
                check("rand_sum0", out_sum0, exp[ACC_DW-1:0]);
                check("rand_sum1", out_sum1, exp[2*ACC_DW-1:ACC_DW]);
            end
            @(negedge clk);
            guard++;
            if (hs) done = 1'b1;
        end
        out_ready = 1'b0;
        if (!done) check("rand_result_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{len: 1, dat: 3,    wt0: -2,   wt1: 5,   bubbles: 0, hold: 0, poke_start: 0, exp0: -6,    exp1: 15,     exp_cyc: 3};
        vecs[1]  = '{len: 4, dat: -128, wt0: -128, wt1: 127, bubbles: 1, hold: 0, poke_start: 0, exp0: 65536, exp1: -65024, exp_cyc: 3};
        vecs[2]  = '{len: 2, dat: 1,    wt0: 1,    wt1: -1,  bubbles: 0, hold: 5, poke_start: 1, exp0: 2,     exp1: -2,     exp_cyc: 3};
        vecs[3]  = '{len: 0, dat: 0,    wt0: 0,    wt1: 0,   bubbles: 0, hold: 1, poke_start: 0, exp0: 0,     exp1: 0,      exp_cyc: 1};
        post_rst = '{len: 1, dat: 2,    wt0: 3,    wt1: 4,   bubbles: 0, hold: 0, poke_start: 0, exp0: 6,     exp1: 8,      exp_cyc: 3};

        rst       = 1'b1;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_dat    = '0;
        in_wt0    = '0;
        in_wt1    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_job(vecs[i]);

        // reset in the middle of a job
        start   = 1'b1;
        cfg_len = LEN_W'(8);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("abort_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_dat   = 8'(b + 5);
            in_wt0   = 8'(b + 7);
            in_wt1   = 8'(b + 9);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("midrun_reset");
        run_job(post_rst);

        for (int j = 0; j < NJOBS; j++) random_job();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
